// File: rtl/random_gen_pkg.sv
// random_gen_pkg: shared constants, opcode table and helpers for the instruction generator
package random_gen_pkg;
   localparam logic [15:0] HALT_INSTR = 16'hE000;
   localparam logic [15:0] LFSR_TAPS  = 16'hB400;
   localparam logic [4:0] OPCODE_TABLE [0:7] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
   typedef enum logic {FILL, DONE} gen_state_t;
   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return (l >> 1) ^ (l[0] ? LFSR_TAPS : 16'h0000);
   endfunction
   function automatic logic [15:0] make_instr(input logic [15:0] l);
      return {OPCODE_TABLE[l[15:13]], l[10:0]};
   endfunction
endpackage

// File: rtl/random_instr_gen_if.sv
// random_instr_gen_if: regenerate request, completion flag and program image
interface random_instr_gen_if #(parameter int MEM_SIZE = 64);
   logic        start;
   logic        done;
   logic [15:0] MEM [MEM_SIZE-1:0];
   modport master (output start, input done, MEM);
   modport slave  (input start, output done, MEM);
endinterface

// File: rtl/random_instr_gen_lfsr16.sv
// lfsr16: 16-bit right-shifting Galois LFSR; a zero seed is replaced by 1 so it never locks up
module lfsr16
   import random_gen_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        advance,
   output logic [15:0] q
);
   logic [15:0] seed_nz;
   assign seed_nz = (seed == 16'h0000) ? 16'h0001 : seed;
   // reset or load takes the seed; otherwise step only when asked
   always_ff @(posedge clk)
      q <= (!rst_n || load) ? seed_nz : advance ? lfsr_step(q) : q;
endmodule

// File: rtl/random_instr_gen.sv
// random_instr_gen: fills a program image with LFSR-derived legal instructions ending in HALT
module random_instr_gen
   import random_gen_pkg::*;
#(
   parameter int          MEM_SIZE = 64,
   parameter logic [15:0] SEED     = 16'hACE1
) (
   input logic               clk,
   input logic               rst_n,
   random_instr_gen_if.slave bus
);
   localparam int IW = $clog2(MEM_SIZE);
   gen_state_t    state_q, state_d;
   logic [IW-1:0] idx;
   logic [15:0]   lfsr;
   logic [15:0]   mem_q [MEM_SIZE-1:0];
   logic          last, advance;
   assign last     = idx == IW'(MEM_SIZE - 1);
   assign bus.MEM  = mem_q;
   assign bus.done = state_q == DONE;
   lfsr16 u_lfsr (.clk(clk), .rst_n(rst_n), .load(1'b0), .seed(SEED), .advance(advance), .q(lfsr));
   // next state: FILL runs to the last word, DONE waits for start
   always_comb begin
      state_d = state_q;
      advance = 1'b0;
      if (state_q == FILL) begin
         state_d = last ? DONE : FILL;
         advance = !last;
      end else begin
         state_d = bus.start ? FILL : DONE;
      end
   end
   // state register
   always_ff @(posedge clk)
      state_q <= !rst_n ? FILL : state_d;
   // write pointer: steps with the LFSR, rewinds on a regenerate request
   always_ff @(posedge clk)
      if (!rst_n)
         idx <= '0;
      else if (advance)
         idx <= idx + 1'b1;
      else if (state_q == DONE && bus.start)
         idx <= '0;
   // program image: HALT everywhere on reset, one word per FILL cycle, last word always HALT
   always_ff @(posedge clk)
      if (!rst_n)
         for (int i = 0; i < MEM_SIZE; i++) mem_q[i] <= HALT_INSTR;
      else if (state_q == FILL)
         mem_q[idx] <= last ? HALT_INSTR : make_instr(lfsr);
endmodule

// File: tb/tb_random_instr_gen.sv
// tb_random_instr_gen: randomized checks of the instruction generator against a program model
module tb_random_instr_gen;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int passed = 0;
   logic [15:0] m_lfsr;
   logic [15:0] exp_mem [64];
   logic [15:0] prev_mem [64];

   random_instr_gen_if #(.MEM_SIZE(64)) bus_a ();
   random_instr_gen_if #(.MEM_SIZE(64)) bus_z ();
   random_instr_gen #(.MEM_SIZE(64), .SEED(16'hACE1)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   random_instr_gen #(.MEM_SIZE(64), .SEED(16'h0000)) u_z (.clk(clk), .rst_n(rst_n), .bus(bus_z));

   always #5 clk = ~clk;

   function automatic logic [15:0] step(input logic [15:0] l);
      return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
   endfunction

   // whole program from the current model LFSR: 63 random words then HALT
   task automatic model_fill();
      for (int i = 0; i < 63; i++) begin
         exp_mem[i] = {2'b00, m_lfsr[15:13], m_lfsr[10:0]};
         m_lfsr = step(m_lfsr);
      end
      exp_mem[63] = 16'hE000;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus_a.start = 1'b0;
      bus_z.start = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (bus_a.MEM[i] !== 16'hE000) $display("FAIL reset_mem[%0d] got %h want e000", i, bus_a.MEM[i]);
         else passed++;
      end
      checks++;
      if (bus_a.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus_a.done);
      else passed++;
      m_lfsr = 16'hACE1;
      model_fill();
   endtask

   task automatic test_first_words();
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus_a.MEM[0] !== exp_mem[0]) $display("FAIL first_mem0 got %h want %h", bus_a.MEM[0], exp_mem[0]);
      else passed++;
      checks++;
      if (bus_a.done !== 1'b0) $display("FAIL first_done got %b want 0", bus_a.done);
      else passed++;
      @(negedge clk);
      checks++;
      if (bus_a.MEM[1] !== 16'h3A70) $display("FAIL first_mem1 got %h want 3a70", bus_a.MEM[1]);
      else passed++;
   endtask

   task automatic test_full_fill();
      repeat (61) @(negedge clk);
      checks++;
      if (bus_a.done !== 1'b0) $display("FAIL fill_early_done got %b want 0", bus_a.done);
      else passed++;
      @(negedge clk);
      checks++;
      if (bus_a.done !== 1'b1) $display("FAIL fill_done got %b want 1", bus_a.done);
      else passed++;
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (bus_a.MEM[i] !== exp_mem[i]) $display("FAIL fill_mem[%0d] got %h want %h", i, bus_a.MEM[i], exp_mem[i]);
         else passed++;
      end
      for (int i = 0; i < 63; i++) begin
         checks++;
         if (bus_a.MEM[i][15:11] > 5'd7) $display("FAIL fill_opcode[%0d] got %h want <=7", i, bus_a.MEM[i][15:11]);
         else passed++;
      end
   endtask

   task automatic test_hold();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if (bus_a.done !== 1'b1) $display("FAIL hold_done cyc %0d got %b want 1", c, bus_a.done);
         else passed++;
         for (int i = 0; i < 64; i++) begin
            checks++;
            if (bus_a.MEM[i] !== exp_mem[i]) $display("FAIL hold_mem[%0d] cyc %0d got %h want %h", i, c, bus_a.MEM[i], exp_mem[i]);
            else passed++;
         end
      end
   endtask

   task automatic test_regen();
      int k;
      logic [15:0] old0;
      repeat ($urandom_range(0, 5)) @(negedge clk);
      old0 = bus_a.MEM[0];
      model_fill();
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      checks++;
      if (bus_a.done !== 1'b0) $display("FAIL regen_done_drop got %b want 0", bus_a.done);
      else passed++;
      @(negedge clk);
      checks++;
      if (bus_a.MEM[0] !== exp_mem[0]) $display("FAIL regen_mem0 got %h want %h", bus_a.MEM[0], exp_mem[0]);
      else passed++;
      checks++;
      if (bus_a.MEM[0] === old0) $display("FAIL regen_mem0_changed got %h want not %h", bus_a.MEM[0], old0);
      else passed++;
      k = $urandom_range(3, 40);
      for (int j = 1; j <= 63; j++) begin
         bus_a.start = (j == k);
         @(negedge clk);
         if (j == 62) begin
            checks++;
            if (bus_a.done !== 1'b0) $display("FAIL regen_early_done got %b want 0", bus_a.done);
            else passed++;
         end
      end
      bus_a.start = 1'b0;
      checks++;
      if (bus_a.done !== 1'b1) $display("FAIL regen_done got %b want 1", bus_a.done);
      else passed++;
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (bus_a.MEM[i] !== exp_mem[i]) $display("FAIL regen_mem[%0d] got %h want %h", i, bus_a.MEM[i], exp_mem[i]);
         else passed++;
      end
   endtask

   task automatic test_reset_mid_fill();
      int k;
      k = $urandom_range(5, 60);
      prev_mem = exp_mem;
      model_fill();
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      repeat (k) @(negedge clk);
      checks++;
      if (bus_a.MEM[k-1] !== exp_mem[k-1]) $display("FAIL abort_new[%0d] got %h want %h", k - 1, bus_a.MEM[k-1], exp_mem[k-1]);
      else passed++;
      for (int i = k; i < 63; i++) begin
         checks++;
         if (bus_a.MEM[i] !== prev_mem[i]) $display("FAIL abort_old[%0d] got %h want %h", i, bus_a.MEM[i], prev_mem[i]);
         else passed++;
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (bus_a.MEM[i] !== 16'hE000) $display("FAIL abort_mem[%0d] got %h want e000", i, bus_a.MEM[i]);
         else passed++;
      end
      checks++;
      if (bus_a.done !== 1'b0) $display("FAIL abort_done got %b want 0", bus_a.done);
      else passed++;
      m_lfsr = 16'hACE1;
      model_fill();
      @(negedge clk);
      checks++;
      if (bus_a.MEM[0] !== exp_mem[0]) $display("FAIL abort_refill0 got %h want %h", bus_a.MEM[0], exp_mem[0]);
      else passed++;
      repeat (63) @(negedge clk);
      checks++;
      if (bus_a.done !== 1'b1) $display("FAIL abort_redone got %b want 1", bus_a.done);
      else passed++;
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (bus_a.MEM[i] !== exp_mem[i]) $display("FAIL abort_refill[%0d] got %h want %h", i, bus_a.MEM[i], exp_mem[i]);
         else passed++;
      end
   endtask

   task automatic test_zero_seed();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_lfsr = 16'h0001;
      model_fill();
      for (int c = 0; c < 64; c++) begin
         checks++;
         if (u_z.u_lfsr.q === 16'h0000) $display("FAIL zero_lfsr cyc %0d got 0000 want nonzero", c);
         else passed++;
         @(negedge clk);
      end
      checks++;
      if (bus_z.MEM[0] !== 16'h0001) $display("FAIL zero_mem0 got %h want 0001", bus_z.MEM[0]);
      else passed++;
      checks++;
      if (bus_z.done !== 1'b1) $display("FAIL zero_done got %b want 1", bus_z.done);
      else passed++;
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (bus_z.MEM[i] !== exp_mem[i]) $display("FAIL zero_mem[%0d] got %h want %h", i, bus_z.MEM[i], exp_mem[i]);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_first_words();
      test_full_fill();
      test_hold();
      test_regen();
      test_reset_mid_fill();
      test_zero_seed();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
